// File: rtl/udp_tx_csum.sv
`default_nettype none
// ============================================================================
// Module   : udp_tx_csum
// Purpose  : UDP transmit framer. Buffers the payload while summing the
//            RFC 768 checksum, then sends header, payload and zero padding.
// Revision : 1.0 - initial release
// ============================================================================
module udp_tx_csum #(
    parameter int MAX_LEN = 1472,
    parameter int MIN_LEN = 18,
    parameter int CSUM_EN = 1,
    parameter int ADDR_W  = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fs,
    output logic        fd,
    input  logic [31:0] src_ip,
    input  logic [31:0] det_ip,
    input  logic [15:0] src_port,
    input  logic [15:0] det_port,
    input  logic [15:0] data_len,
    output logic        fifo_rxen,
    input  logic [7:0]  fifo_rxd,
    output logic [7:0]  txd,
    output logic        txv
);

    localparam logic [15:0] c_max_len = 16'(MAX_LEN);
    localparam logic [15:0] c_min_len = 16'(MIN_LEN);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_WAIT = 4'd1,
        S_LOAD = 4'd2,
        S_LAST = 4'd3,
        S_FOLD = 4'd4,
        S_HDR  = 4'd5,
        S_PAY  = 4'd6,
        S_PAD  = 4'd7,
        S_DONE = 4'd8
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [15:0]       r_cnt;
    logic [ADDR_W-1:0] r_cnt_d;
    logic              r_rxen_d;
    logic [31:0]       r_acc;
    logic [7:0]        r_txd;
    logic              r_txv;
    logic              r_fd;
    logic [7:0]        r_buf [0:(2**ADDR_W)-1];
    logic [7:0]        r_rd_data;

    logic [15:0]       w_len;
    logic [15:0]       w_plen;
    logic [15:0]       w_pad;
    logic [15:0]       w_udp_len;
    logic [31:0]       w_acc_init;
    logic [31:0]       w_acc_byte;
    logic [15:0]       w_fold;
    logic [15:0]       w_csum;
    logic [7:0]        w_hdr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_rxen;

    assign w_len     = (data_len > c_max_len) ? c_max_len : data_len;
    assign w_plen    = (w_len < c_min_len) ? c_min_len : w_len;
    assign w_pad     = w_plen - w_len;
    assign w_udp_len = w_plen + 16'd8;

    assign w_acc_init = 32'(src_ip[31:16]) + 32'(src_ip[15:0])
                      + 32'(det_ip[31:16]) + 32'(det_ip[15:0])
                      + 32'h0000_0011
                      + 32'(w_udp_len) + 32'(w_udp_len)
                      + 32'(src_port) + 32'(det_port);

    // Even payload index is the high byte of its 16-bit word.
    assign w_acc_byte = r_cnt_d[0] ? {24'd0, fifo_rxd} : {16'd0, fifo_rxd, 8'd0};

    assign w_fold = ~r_acc[15:0];
    assign w_csum = (CSUM_EN == 0)     ? 16'h0000 :
                    (w_fold == 16'h0)  ? 16'hFFFF : w_fold;

    always_comb begin
        w_hdr = 8'h00;
        case (r_cnt[2:0])
            3'd0: w_hdr = src_port[15:8];
            3'd1: w_hdr = src_port[7:0];
            3'd2: w_hdr = det_port[15:8];
            3'd3: w_hdr = det_port[7:0];
            3'd4: w_hdr = w_udp_len[15:8];
            3'd5: w_hdr = w_udp_len[7:0];
            3'd6: w_hdr = w_csum[15:8];
            default: w_hdr = w_csum[7:0];
        endcase
    end

    assign w_rxen    = (r_state == S_LOAD) && (r_cnt < w_len);
    // Byte 0 is addressed during the last header cycle so payload is gapless.
    assign w_rd_addr = (r_state == S_HDR) ? '0 : ADDR_W'(r_cnt + 16'd1);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: w_state_nx = S_WAIT;
            S_WAIT: if (fs) w_state_nx = S_LOAD;
            S_LOAD: if ((r_cnt + 16'd1) >= w_len) w_state_nx = S_LAST;
            S_LAST: w_state_nx = S_FOLD;
            S_FOLD: if (r_cnt == 16'd1) w_state_nx = S_HDR;
            S_HDR:  if (r_cnt == 16'd7) w_state_nx = (w_len == 16'd0) ? S_PAD : S_PAY;
            S_PAY:  if (r_cnt == w_len - 16'd1) w_state_nx = (w_pad == 16'd0) ? S_DONE : S_PAD;
            S_PAD:  if (r_cnt == w_pad - 16'd1) w_state_nx = S_DONE;
            S_DONE: if (!fs) w_state_nx = S_WAIT;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 16'd0;
            r_cnt_d  <= '0;
            r_rxen_d <= 1'b0;
            r_acc    <= 32'd0;
            r_txd    <= 8'h00;
            r_txv    <= 1'b0;
            r_fd     <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= (w_state_nx != r_state) ? 16'd0 : r_cnt + 16'd1;
            r_cnt_d  <= r_cnt[ADDR_W-1:0];
            r_rxen_d <= w_rxen;
            // fd lags the state like txv, so it rises after the last byte.
            r_fd     <= (r_state == S_DONE);

            if (r_state == S_WAIT && fs) begin
                r_acc <= w_acc_init;
            end else if (r_rxen_d) begin
                r_acc <= r_acc + w_acc_byte;
            end else if (r_state == S_FOLD) begin
                r_acc <= 32'(r_acc[15:0]) + 32'(r_acc[31:16]);
            end

            case (r_state)
                S_HDR: begin
                    r_txv <= 1'b1;
                    r_txd <= w_hdr;
                end
                S_PAY: begin
                    r_txv <= 1'b1;
                    r_txd <= r_rd_data;
                end
                S_PAD: begin
                    r_txv <= 1'b1;
                    r_txd <= 8'h00;
                end
                default: begin
                    r_txv <= 1'b0;
                    r_txd <= 8'h00;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_rxen_d) begin
            r_buf[r_cnt_d] <= fifo_rxd;
        end
        r_rd_data <= r_buf[w_rd_addr];
    end

    assign fifo_rxen = w_rxen;
    assign txd       = r_txd;
    assign txv       = r_txv;
    assign fd        = r_fd;

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_csum.sv
`default_nettype none
// Testbench for udp_tx_csum: two instances (checksum on/off) share stimulus;
// frames are compared against a byte-level RFC 768 reference model.
module tb_udp_tx_csum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fs  = 1'b0;
    logic [31:0] src_ip = 32'd0;
    logic [31:0] det_ip = 32'd0;
    logic [15:0] src_port = 16'd0;
    logic [15:0] det_port = 16'd0;
    logic [15:0] data_len = 16'd0;
    logic [7:0]  fifo_rxd = 8'h00;

    logic        fd_a, fifo_rxen_a, txv_a;
    logic [7:0]  txd_a;
    logic        fd_n, fifo_rxen_n, txv_n;
    logic [7:0]  txd_n;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    udp_tx_csum #(.MAX_LEN(32), .MIN_LEN(18), .CSUM_EN(1), .ADDR_W(5)) u_dut (
        .clk(clk), .rst(rst), .fs(fs), .fd(fd_a),
        .src_ip(src_ip), .det_ip(det_ip), .src_port(src_port), .det_port(det_port),
        .data_len(data_len), .fifo_rxen(fifo_rxen_a), .fifo_rxd(fifo_rxd),
        .txd(txd_a), .txv(txv_a)
    );

    udp_tx_csum #(.MAX_LEN(32), .MIN_LEN(18), .CSUM_EN(0), .ADDR_W(5)) u_nc (
        .clk(clk), .rst(rst), .fs(fs), .fd(fd_n),
        .src_ip(src_ip), .det_ip(det_ip), .src_port(src_port), .det_port(det_port),
        .data_len(data_len), .fifo_rxen(fifo_rxen_n), .fifo_rxd(fifo_rxd),
        .txd(txd_n), .txv(txv_n)
    );

    // Upstream FIFO: data appears the cycle after each read strobe.
    logic [7:0] pay [0:63];
    int rd_total = 0;
    int rd_base  = 0;
    always @(posedge clk) begin
        if (fifo_rxen_a) begin
            fifo_rxd <= pay[(rd_total - rd_base) & 63];
            rd_total <= rd_total + 1;
        end
    end

    // Observations of the last frame
    logic [7:0] obs_a[$];
    logic [7:0] obs_n[$];
    logic [7:0] exp_a[$];
    logic [7:0] exp_n[$];
    int o_rxen, o_rxen_diff, o_first, o_last, o_fd_at, o_after;
    bit o_gap, o_timeout;
    int exp_l, exp_p;

    task automatic build_expected();
        int unsigned sum;
        logic [15:0] c;
        logic [15:0] ul;
        logic [7:0]  hi, lo;
        exp_l = (int'(data_len) > 32) ? 32 : int'(data_len);
        exp_p = (exp_l < 18) ? 18 : exp_l;
        ul    = 16'(exp_p + 8);
        sum = src_ip[31:16] + src_ip[15:0] + det_ip[31:16] + det_ip[15:0]
            + 32'd17 + ul + src_port + det_port + ul;
        for (int k = 0; k < exp_p; k += 2) begin
            hi = (k < exp_l) ? pay[k] : 8'h00;
            lo = (k + 1 < exp_l) ? pay[k+1] : 8'h00;
            sum += {16'd0, hi, lo};
        end
        while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
        c = ~sum[15:0];
        if (c == 16'h0000) c = 16'hFFFF;
        exp_a = {src_port[15:8], src_port[7:0], det_port[15:8], det_port[7:0],
                 ul[15:8], ul[7:0], c[15:8], c[7:0]};
        exp_n = {src_port[15:8], src_port[7:0], det_port[15:8], det_port[7:0],
                 ul[15:8], ul[7:0], 8'h00, 8'h00};
        for (int k = 0; k < exp_p; k++) begin
            exp_a.push_back((k < exp_l) ? pay[k] : 8'h00);
            exp_n.push_back((k < exp_l) ? pay[k] : 8'h00);
        end
    endtask

    function automatic int n_diff(input logic [7:0] a[$], input logic [7:0] b[$]);
        int n = 0;
        if (a.size() != b.size()) return -1;
        for (int k = 0; k < a.size(); k++) if (a[k] !== b[k]) n++;
        return n;
    endfunction

    // Runs one frame from fs high to fd, then releases fs.
    task automatic run_frame(input int hold);
        bit done = 0;
        rd_base = rd_total;
        obs_a.delete(); obs_n.delete();
        o_rxen = 0; o_rxen_diff = 0; o_first = -1; o_last = -1; o_fd_at = -1;
        o_after = 0; o_gap = 0; o_timeout = 0;
        if (!fs) begin
            @(negedge clk);
            fs = 1'b1;
        end
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (fifo_rxen_a) o_rxen++;
            if (fifo_rxen_a !== fifo_rxen_n) o_rxen_diff++;
            if (fd_a && o_fd_at < 0) o_fd_at = i;
            if (txv_a) begin
                obs_a.push_back(txd_a);
                if (o_first < 0) o_first = i;
                else if (i != o_last + 1) o_gap = 1;
                o_last = i;
                if (o_fd_at >= 0) o_after++;
            end
            if (txv_n) obs_n.push_back(txd_n);
            if (o_fd_at >= 0 && i >= o_fd_at + hold) begin
                done = 1;
                break;
            end
        end
        if (!done) o_timeout = 1;
        fs = 1'b0;
        done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!fd_a) begin
                done = 1;
                break;
            end
        end
        if (!done) o_timeout = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (txv_a !== 1'b0 || txd_a !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_tx: txv=%b txd=%h, required 0/00", txv_a, txd_a);
        end
        n_checks++;
        if (fifo_rxen_a !== 1'b0 || fd_a !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctl: rxen=%b fd=%b, required 0/0", fifo_rxen_a, fd_a);
        end
        n_checks++;
        if (txv_n !== 1'b0 || fd_n !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_nc: txv=%b fd=%b, required 0/0", txv_n, fd_n);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_known_vector();
        logic [7:0] hdr[$];
        logic [7:0] got[$];
        src_ip = 32'hC0A80001; det_ip = 32'hC0A80002;
        src_port = 16'h1234; det_port = 16'h5678; data_len = 16'd20;
        for (int k = 0; k < 64; k++) pay[k] = 8'h00;
        build_expected();
        run_frame(0);
        hdr = {8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h1C, 8'h15, 8'hB6};
        got = obs_a[0:7];
        n_checks++;
        if (obs_a.size() < 8 || n_diff(got, hdr) != 0) begin
            n_errors++;
            $display("FAIL known_hdr: got %p, required %p", got, hdr);
        end
        n_checks++;
        if (obs_a.size() != 28 || o_rxen != 20 || o_timeout) begin
            n_errors++;
            $display("FAIL known_counts: txv=%0d rxen=%0d to=%0b, required 28/20/0",
                     obs_a.size(), o_rxen, o_timeout);
        end
        n_checks++;
        if (o_first - 1 != 24) begin
            n_errors++;
            $display("FAIL known_latency: %0d cycles, required 24", o_first - 1);
        end
    endtask

    task automatic test_padding();
        src_ip = $urandom; det_ip = $urandom;
        src_port = 16'($urandom); det_port = 16'($urandom); data_len = 16'd4;
        for (int k = 0; k < 64; k++) pay[k] = 8'($urandom);
        build_expected();
        run_frame(0);
        n_checks++;
        if (obs_a.size() != 26 || o_rxen != 4 || o_timeout) begin
            n_errors++;
            $display("FAIL pad_counts: txv=%0d rxen=%0d, required 26/4", obs_a.size(), o_rxen);
        end
        n_checks++;
        if (obs_a.size() != 26 || obs_a[4] !== 8'h00 || obs_a[5] !== 8'h1A) begin
            n_errors++;
            $display("FAIL pad_udp_len: got %p, required udp_len 001A", obs_a);
        end
        n_checks++;
        if (n_diff(obs_a, exp_a) != 0) begin
            n_errors++;
            $display("FAIL pad_bytes: got %p, required %p", obs_a, exp_a);
        end
    endtask

    task automatic test_zero_payload();
        src_port = 16'($urandom); det_port = 16'($urandom); data_len = 16'd0;
        build_expected();
        run_frame(0);
        n_checks++;
        if (o_rxen != 0 || obs_a.size() != 26 || o_timeout) begin
            n_errors++;
            $display("FAIL zero_counts: rxen=%0d txv=%0d, required 0/26", o_rxen, obs_a.size());
        end
        n_checks++;
        if (n_diff(obs_a, exp_a) != 0) begin
            n_errors++;
            $display("FAIL zero_bytes: got %p, required %p", obs_a, exp_a);
        end
        n_checks++;
        if (o_first - 1 != 5) begin
            n_errors++;
            $display("FAIL zero_latency: %0d cycles, required 5", o_first - 1);
        end
    endtask

    task automatic test_odd_nocsum();
        data_len = 16'd19;
        for (int k = 0; k < 64; k++) pay[k] = 8'(k + 1);
        build_expected();
        run_frame(0);
        n_checks++;
        if (obs_n.size() != 27 || obs_n[6] !== 8'h00 || obs_n[7] !== 8'h00) begin
            n_errors++;
            $display("FAIL odd_nc_csum: got %p, required 27 bytes with csum 0000", obs_n);
        end
        n_checks++;
        if (n_diff(obs_n, exp_n) != 0) begin
            n_errors++;
            $display("FAIL odd_nc_bytes: got %p, required %p", obs_n, exp_n);
        end
        n_checks++;
        if (n_diff(obs_a, exp_a) != 0) begin
            n_errors++;
            $display("FAIL odd_bytes: got %p, required %p", obs_a, exp_a);
        end
    endtask

    task automatic test_truncation();
        data_len = 16'd40;
        for (int k = 0; k < 64; k++) pay[k] = 8'($urandom);
        build_expected();
        run_frame(0);
        n_checks++;
        if (o_rxen != 32 || obs_a.size() != 40 || o_timeout) begin
            n_errors++;
            $display("FAIL trunc_counts: rxen=%0d txv=%0d, required 32/40", o_rxen, obs_a.size());
        end
        n_checks++;
        if (n_diff(obs_a, exp_a) != 0) begin
            n_errors++;
            $display("FAIL trunc_bytes: got %p, required %p", obs_a, exp_a);
        end
    endtask

    task automatic test_fs_hold();
        data_len = 16'($urandom_range(0, 40));
        for (int k = 0; k < 64; k++) pay[k] = 8'($urandom);
        build_expected();
        run_frame(8);
        n_checks++;
        if (o_after != 0 || o_rxen != exp_l || obs_a.size() != exp_p + 8 || o_timeout) begin
            n_errors++;
            $display("FAIL fs_hold: after=%0d rxen=%0d txv=%0d, required 0/%0d/%0d",
                     o_after, o_rxen, obs_a.size(), exp_l, exp_p + 8);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            src_ip = $urandom; det_ip = $urandom;
            src_port = 16'($urandom); det_port = 16'($urandom);
            data_len = 16'($urandom_range(0, 40));
            for (int k = 0; k < 64; k++) pay[k] = 8'($urandom);
            build_expected();
            run_frame(1);
            n_checks++;
            if (n_diff(obs_a, exp_a) != 0 || n_diff(obs_n, exp_n) != 0) begin
                n_errors++;
                $display("FAIL rand_bytes len=%0d: got %p, required %p", data_len, obs_a, exp_a);
            end
            n_checks++;
            if (o_gap || o_fd_at != o_last + 1 || o_after != 0 || o_timeout || o_rxen_diff != 0) begin
                n_errors++;
                $display("FAIL rand_timing len=%0d: gap=%0b fd_at=%0d last=%0d to=%0b rxdiff=%0d, required fd_at=last+1",
                         data_len, o_gap, o_fd_at, o_last, o_timeout, o_rxen_diff);
            end
            n_checks++;
            if (o_first - 1 != ((exp_l > 1) ? exp_l : 1) + 4) begin
                n_errors++;
                $display("FAIL rand_latency len=%0d: %0d, required %0d",
                         data_len, o_first - 1, ((exp_l > 1) ? exp_l : 1) + 4);
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        bit reached = 0;
        data_len = 16'd10;
        for (int k = 0; k < 64; k++) pay[k] = 8'($urandom);
        rd_base = rd_total;
        @(negedge clk);
        fs = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (txv_a) seen++;
            if (seen >= 12) begin
                reached = 1;
                break;
            end
        end
        n_checks++;
        if (!reached) begin
            n_errors++;
            $display("FAIL mid_reach: saw %0d bytes, required 12", seen);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (txv_a !== 1'b0 || fd_a !== 1'b0 || fifo_rxen_a !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset: txv=%b fd=%b rxen=%b, required 0/0/0", txv_a, fd_a, fifo_rxen_a);
        end
        repeat (3) @(negedge clk);
        data_len = 16'd7;
        for (int k = 0; k < 64; k++) pay[k] = 8'($urandom);
        build_expected();
        rst = 1'b0;
        run_frame(0);
        n_checks++;
        if (n_diff(obs_a, exp_a) != 0 || o_rxen != 7 || o_timeout) begin
            n_errors++;
            $display("FAIL mid_restart: got %p rxen=%0d, required %p rxen=7", obs_a, o_rxen, exp_a);
        end
        n_checks++;
        if (o_first - 1 != 7 + 4 + 1) begin
            n_errors++;
            $display("FAIL mid_latency: %0d, required 12", o_first - 1);
        end
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_padding();
        test_zero_payload();
        test_odd_nocsum();
        test_truncation();
        test_fs_hold();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
